// File: rtl/cmplx_mult_seq_if.sv
// Bundles the upstream operand handshake, the shared-multiplier control/data
// lines and the downstream result handshake of the complex-product sequencer.
// The sequencer attaches through the slave modport; the surrounding fabric uses master.
interface cmplx_mult_seq_if;

   // upstream operand handshake
   logic                in_valid;
   logic                in_ready;
   logic signed [7:0]   a_re;
   logic signed [7:0]   a_im;
   logic signed [8:0]   w_re;
   logic signed [8:0]   w_im;

   // shared serial multiplier
   logic                mult_start;
   logic signed [7:0]   mult_in0;
   logic signed [8:0]   mult_in1;
   logic                mult_valid;
   logic signed [16:0]  mult_prod;

   // downstream result handshake
   logic                out_valid;
   logic                out_ready;
   logic signed [17:0]  y_re;
   logic signed [17:0]  y_im;

   // sticky fault flag
   logic                err;

   // sequencer side
   modport slave (
      input  in_valid, a_re, a_im, w_re, w_im,
      input  mult_valid, mult_prod,
      input  out_ready,
      output in_ready,
      output mult_start, mult_in0, mult_in1,
      output out_valid, y_re, y_im,
      output err
   );

   // butterfly buffer / multiplier / consumer side
   modport master (
      output in_valid, a_re, a_im, w_re, w_im,
      output mult_valid, mult_prod,
      output out_ready,
      input  in_ready,
      input  mult_start, mult_in0, mult_in1,
      input  out_valid, y_re, y_im,
      input  err
   );

endinterface

// File: rtl/cmplx_mult_seq.sv
// Complex product y = a * w built from four passes through one shared 8x9 serial multiplier.
// Latency: out_valid rises one cycle after the 4th mult_valid, about 4*(1+18)+2 cycles after accept.
// Backpressure: in_ready only in IDLE; y held stable while out_valid & !out_ready; FAULT is left only by rst.
module cmplx_mult_seq #(
   parameter int TIMEOUT = 32,
   parameter int SETTLE  = 20
) (
   input  logic              clk,
   input  logic              rst,
   cmplx_mult_seq_if.slave   bus
);

   localparam int SW = (SETTLE  > 1) ? $clog2(SETTLE  + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_SETTLE = 3'd0,
      S_IDLE   = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_OUT    = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [SW-1:0]       r_settle_cnt;
   logic [TW-1:0]       r_tmo_cnt;
   logic [1:0]          r_idx;

   // captured operands, stable for the whole four-pass job
   logic signed [7:0]   r_a_re;
   logic signed [7:0]   r_a_im;
   logic signed [8:0]   r_w_re;
   logic signed [8:0]   r_w_im;

   logic signed [17:0]  r_acc_re;
   logic signed [17:0]  r_acc_im;
   logic signed [17:0]  r_y_re;
   logic signed [17:0]  r_y_im;
   logic                r_err;

   logic                w_in_ready;
   logic                w_mult_start;
   logic                w_out_valid;
   logic signed [7:0]   w_op0;
   logic signed [8:0]   w_op1;
   logic signed [17:0]  w_prod_sx;
   logic signed [17:0]  w_acc_re_nxt;
   logic signed [17:0]  w_acc_im_nxt;
   logic                w_settle_done;
   logic                w_tmo_hit;
   logic                w_last;
   logic                w_accept;
   logic                w_prod_take;
   logic                w_tmo_fire;

   assign w_prod_sx     = {bus.mult_prod[16], bus.mult_prod};
   assign w_settle_done = (r_settle_cnt == SW'(SETTLE - 1));
   assign w_tmo_hit     = (r_tmo_cnt == TW'(TIMEOUT - 1));
   assign w_last        = (r_idx == 2'd3);
   assign w_accept      = (r_state == S_IDLE) && bus.in_valid;
   // products are only meaningful while a job is outstanding; strays elsewhere are dropped
   assign w_prod_take   = (r_state == S_WAIT) && bus.mult_valid;
   // a product arriving on the timeout cycle wins over the fault
   assign w_tmo_fire    = (r_state == S_WAIT) && !bus.mult_valid && w_tmo_hit;

   // select the operand pair for the current partial product
   always_comb begin
      w_op0 = r_a_re;
      w_op1 = r_w_re;
      case (r_idx)
         2'd0:    begin w_op0 = r_a_re; w_op1 = r_w_re; end
         2'd1:    begin w_op0 = r_a_im; w_op1 = r_w_im; end
         2'd2:    begin w_op0 = r_a_re; w_op1 = r_w_im; end
         default: begin w_op0 = r_a_im; w_op1 = r_w_re; end
      endcase
   end

   // fold the returning partial product into the real or imaginary sum
   always_comb begin
      w_acc_re_nxt = r_acc_re;
      w_acc_im_nxt = r_acc_im;
      case (r_idx)
         2'd0:    w_acc_re_nxt = r_acc_re + w_prod_sx;
         2'd1:    w_acc_re_nxt = r_acc_re - w_prod_sx;
         default: w_acc_im_nxt = r_acc_im + w_prod_sx;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_SETTLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode and per-state handshake outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_in_ready   = 1'b0;
      w_mult_start = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         S_SETTLE: begin
            if (w_settle_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_mult_start = 1'b1;
            w_state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mult_valid) begin
               w_state_nxt = w_last ? S_OUT : S_ISSUE;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_FAULT;
            end
         end
         S_OUT: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FAULT: begin
            w_state_nxt = S_FAULT;
         end
         default: begin
            w_state_nxt = S_SETTLE;
         end
      endcase
   end

   // post-reset hold-off so a multiplier job orphaned by reset can finish unseen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_settle_cnt <= '0;
      end else if (r_state == S_SETTLE) begin
         r_settle_cnt <= r_settle_cnt + 1'b1;
      end
   end

   // watchdog on each outstanding multiplier job
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT) && !bus.mult_valid && !w_tmo_hit) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // operand capture on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_re <= '0;
         r_a_im <= '0;
         r_w_re <= '0;
         r_w_im <= '0;
      end else if (w_accept) begin
         r_a_re <= bus.a_re;
         r_a_im <= bus.a_im;
         r_w_re <= bus.w_re;
         r_w_im <= bus.w_im;
      end
   end

   // pass index and running sums; cleared on accept, advanced per product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= 2'd0;
         r_acc_re <= '0;
         r_acc_im <= '0;
      end else if (w_accept) begin
         r_idx    <= 2'd0;
         r_acc_re <= '0;
         r_acc_im <= '0;
      end else if (w_prod_take) begin
         r_acc_re <= w_acc_re_nxt;
         r_acc_im <= w_acc_im_nxt;
         if (!w_last) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // result register, loaded once from the final sums and held through OUT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_re <= '0;
         r_y_im <= '0;
      end else if (w_prod_take && w_last) begin
         r_y_re <= w_acc_re_nxt;
         r_y_im <= w_acc_im_nxt;
      end
   end

   // sticky fault flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_tmo_fire) begin
         r_err <= 1'b1;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.mult_start = w_mult_start;
   assign bus.mult_in0   = w_op0;
   assign bus.mult_in1   = w_op1;
   assign bus.out_valid  = w_out_valid;
   assign bus.y_re       = r_y_re;
   assign bus.y_im       = r_y_im;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Self-checking bench for cmplx_mult_seq: behavioural 18-cycle multiplier,
// operand/result scoreboards fed at accept time, and a monitor that checks
// every multiplier start and every result handshake.
module tb_cmplx_mult_seq;

   localparam int TIMEOUT = 32;
   localparam int SETTLE  = 20;
   localparam int LAT     = 18;
   localparam int BOUND   = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmplx_mult_seq_if bus ();

   cmplx_mult_seq #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { int a; int w; }   opnd_t;
   typedef struct { int re; int im; } res_t;
   typedef struct { int cnt; int p; } job_t;

   opnd_t exp_ops[$];
   res_t  exp_res[$];
   job_t  jobs[$];

   int cyc = 0;
   int op_starts = 0;
   int results = 0;
   int accepts = 0;
   int res_at_accept = 0;
   int ordy_mode = 0;
   bit drop_third = 0;
   int drop_cnt = 0;
   int third_start_cyc = -1;
   bit stray_req = 0;
   int last_re = 0;
   int last_im = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic int rnd8();
      logic signed [7:0] v;
      v = 8'($urandom);
      return int'(v);
   endfunction

   function automatic int rnd9();
      logic signed [8:0] v;
      v = 9'($urandom);
      return int'(v);
   endfunction

   always @(posedge clk) cyc++;

   // behavioural shared multiplier: product valid LAT cycles after start is sampled
   always @(negedge clk) begin : mult_model
      int p;
      bus.mult_valid = 1'b0;
      bus.mult_prod  = '0;
      foreach (jobs[i]) jobs[i].cnt--;
      if (jobs.size() > 0 && jobs[0].cnt <= 0) begin
         bus.mult_valid = 1'b1;
         bus.mult_prod  = 17'(jobs[0].p);
         void'(jobs.pop_front());
      end else if (stray_req) begin
         bus.mult_valid = 1'b1;
         bus.mult_prod  = 17'($urandom);
         stray_req      = 1'b0;
      end
      if (bus.mult_start === 1'b1) begin
         p = int'(bus.mult_in0) * int'(bus.mult_in1);
         if (drop_third) drop_cnt++;
         if (drop_third && drop_cnt == 3) begin
            third_start_cyc = cyc;
         end else begin
            jobs.push_back('{LAT, p});
         end
      end
   end

   // monitor: drives out_ready, checks operands per start and results per handshake
   always @(negedge clk) begin : monitor
      static bit prev_hold = 1'b0;
      static int prev_re = 0;
      static int prev_im = 0;
      opnd_t o;
      res_t  r;
      bus.out_ready = (ordy_mode == 0) ? 1'b1 :
                      (ordy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      if (rst !== 1'b0) begin
         prev_hold = 1'b0;
      end else begin
         if (bus.mult_start === 1'b1) begin
            op_starts++;
            if (exp_ops.size() == 0) begin
               fail("unexpected_mult_start");
            end else begin
               o = exp_ops.pop_front();
               chk("mult_in0", int'(bus.mult_in0), o.a);
               chk("mult_in1", int'(bus.mult_in1), o.w);
            end
         end
         if (bus.out_valid === 1'b1) begin
            chk("in_ready_during_out", int'(bus.in_ready), 0);
            if (prev_hold) begin
               chk("y_re_held", int'(bus.y_re), prev_re);
               chk("y_im_held", int'(bus.y_im), prev_im);
            end
            if (bus.out_ready) begin
               if (exp_res.size() == 0) begin
                  fail("unexpected_result");
               end else begin
                  r = exp_res.pop_front();
                  chk("y_re", int'(bus.y_re), r.re);
                  chk("y_im", int'(bus.y_im), r.im);
                  chk("starts_per_op", op_starts, 4);
               end
               op_starts = 0;
               results++;
            end
         end
         prev_hold = (bus.out_valid === 1'b1) && !bus.out_ready;
         prev_re   = int'(bus.y_re);
         prev_im   = int'(bus.y_im);
      end
   end

   // offer one operand set; expectations are queued at the accepting edge
   task automatic send(input int ar, input int ai, input int wr, input int wi);
      int n = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1) begin
         if (n >= BOUND) begin
            fail("send_timeout");
            return;
         end
         bus.in_valid = 1'b1;
         bus.a_re = 8'(ar); bus.a_im = 8'(ai);
         bus.w_re = 9'(wr); bus.w_im = 9'(wi);
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b1;
      bus.a_re = 8'(ar); bus.a_im = 8'(ai);
      bus.w_re = 9'(wr); bus.w_im = 9'(wi);
      exp_res.push_back('{ar * wr - ai * wi, ar * wi + ai * wr});
      exp_ops.push_back('{ar, wr});
      exp_ops.push_back('{ai, wi});
      exp_ops.push_back('{ar, wi});
      exp_ops.push_back('{ai, wr});
      last_re = ar * wr - ai * wi;
      last_im = ar * wi + ai * wr;
      op_starts = 0;
      res_at_accept = results;
      accepts++;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(exp_res.size() == 0 && bus.in_ready === 1'b1)) begin
         if (n >= BOUND) begin
            fail("idle_timeout");
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   int'(bus.in_ready),   0);
      chk({tag, "_mult_start"}, int'(bus.mult_start), 0);
      chk({tag, "_mult_in0"},   int'(bus.mult_in0),   0);
      chk({tag, "_mult_in1"},   int'(bus.mult_in1),   0);
      chk({tag, "_out_valid"},  int'(bus.out_valid),  0);
      chk({tag, "_y_re"},       int'(bus.y_re),       0);
      chk({tag, "_y_im"},       int'(bus.y_im),       0);
      chk({tag, "_err"},        int'(bus.err),        0);
   endtask

   // release reset and measure the hold-off before in_ready
   task automatic release_and_settle(input string tag);
      int n = 0;
      @(negedge clk);
      rst = 1'b0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_settle_cycles"}, n, SETTLE);
   endtask

   task automatic flush_expect();
      exp_ops.delete();
      exp_res.delete();
      op_starts = 0;
   endtask

   initial begin
      int n;
      int acc0;
      int hi_cnt;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a_re = '0; bus.a_im = '0; bus.w_re = '0; bus.w_im = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      release_and_settle("init");

      // directed products
      send(3, -2, 100, 50);
      wait_idle();
      send(-128, -128, 255, -256);
      wait_idle();

      // stray product while idle must not disturb the held result
      stray_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_stray_y_re", int'(bus.y_re), last_re);
      chk("idle_stray_y_im", int'(bus.y_im), last_im);
      chk("idle_stray_in_ready", int'(bus.in_ready), 1);

      // back-to-back offers with the consumer stalled
      ordy_mode = 2;
      send(5, 7, -9, 11);
      acc0 = accepts;
      fork
         send(-1, 127, -256, 255);
      join_none
      n = 0;
      while (bus.out_valid !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) fail("out_valid_timeout");
      for (int i = 0; i < 10; i++) begin
         if (i == 3) stray_req = 1'b1;
         @(negedge clk);
         chk("stall_in_ready", int'(bus.in_ready), 0);
         chk("stall_out_valid", int'(bus.out_valid), 1);
         chk("stall_no_accept", accepts, acc0);
      end
      ordy_mode = 0;
      wait fork;
      chk("b2b_accept_after_handshake", res_at_accept, results - 0 - (exp_res.size() == 0 ? 1 : 0));
      wait_idle();

      // dropped third product -> timeout fault
      drop_cnt = 0;
      drop_third = 1'b1;
      send(rnd8(), rnd8(), rnd9(), rnd9());
      n = 0;
      while (bus.err !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) fail("err_timeout");
      else chk("err_latency", cyc - third_start_cyc, TIMEOUT + 1);
      drop_third = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.mult_start !== 1'b0) hi_cnt++;
      end
      chk("fault_quiet_cycles", hi_cnt, 0);
      chk("fault_err_sticky", int'(bus.err), 1);
      rst = 1'b1;
      flush_expect();
      #1;
      check_reset_outputs("fault_rst");
      release_and_settle("fault_rst");

      // reset while waiting on the second product
      send(-77, 101, 200, -150);
      n = 0;
      while (op_starts < 2 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) fail("second_start_timeout");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      flush_expect();
      #1;
      check_reset_outputs("mid_rst");
      release_and_settle("mid_rst");
      send(-2, 9, 13, -40);
      wait_idle();
      chk("post_rst_jobs_drained", jobs.size(), 0);

      // randomized traffic with random consumer stalls
      ordy_mode = 1;
      for (int k = 0; k < 30; k++) begin
         if (k % 10 == 0) send(-128, 127, -256, 255);
         else send(rnd8(), rnd8(), rnd9(), rnd9());
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      wait_idle();
      ordy_mode = 0;
      chk("final_err", int'(bus.err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // hard stop if the sequence itself stalls
   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "global timeout");
   end

endmodule
